// File: rtl/bk_sd_sequencer_if.sv
// rtl/bk_sd_sequencer_if.sv - sector request/ack handshake between sequencer and HPS SD image
interface bk_sd_sequencer_if #(
  parameter int LBA_W = 32
);
  logic [LBA_W-1:0] sd_lba;
  logic             sd_rd;
  logic             sd_wr;
  logic             sd_ack;

  modport master (output sd_lba, sd_rd, sd_wr, input sd_ack);
  modport slave  (input sd_lba, sd_rd, sd_wr, output sd_ack);
endinterface

// File: rtl/bk_sd_sequencer.sv
// rtl/bk_sd_sequencer.sv - BSRAM <-> SD image sector sequencer; optional BK_DIRTY_TRACK_EN skips clean saves
module bk_sd_sequencer #(
  parameter int LBA_W    = 32,
  parameter int MASK_W   = 24,
  parameter int BLK_BITS = 9,
  parameter int TIMEOUT  = 2**24
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              download,
  input  logic              img_mounted,
  input  logic              img_size_nz,
  input  logic              img_readonly,
  input  logic              load_req,
  input  logic              save_req,
  input  logic [MASK_W-1:0] ram_mask,
  input  logic              bsram_wr,
  bk_sd_sequencer_if.master sd,
  output logic              bk_ena,
  output logic              loading,
  output logic              busy,
  output logic              done,
  output logic              err
);
  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

  state_t           state;
  logic             old_dl;
  logic             old_load;
  logic             old_save;
  logic             old_ack;
  logic [31:0]      timer;
  logic [LBA_W-1:0] last;
  logic             dl_rise;
  logic             dl_fall;
  logic             load_edge;
  logic             save_edge;
  logic             ack_rise;
  logic             ack_fall;
  logic             is_load;
  logic             skip_save;
  logic             start;
  logic             time_up;

  assign last      = LBA_W'(ram_mask >> BLK_BITS);
  assign dl_rise   = download & ~old_dl;
  assign dl_fall   = ~download & old_dl;
  assign load_edge = load_req & bk_ena & ~old_load;
  assign save_edge = save_req & bk_ena & ~old_save;
  assign ack_rise  = sd.sd_ack & ~old_ack;
  assign ack_fall  = ~sd.sd_ack & old_ack;
  // Auto-load after a ROM download outranks user requests; load beats save.
  assign is_load   = (dl_fall & bk_ena) | load_edge;
  assign time_up   = (TIMEOUT != 0) && (timer == 32'(TIMEOUT - 1));

`ifdef BK_DIRTY_TRACK_EN
  logic dirty;
  assign skip_save = ~is_load & save_edge & ~dirty;
`else
  logic unused_bsram_wr;
  assign unused_bsram_wr = bsram_wr;
  assign skip_save       = 1'b0;
`endif

  assign start = is_load | (save_edge & ~skip_save);

  always_ff @(posedge clk_sys) begin
    if (!reset) begin
      state     <= IDLE;
      old_dl    <= 1'b0;
      old_load  <= 1'b0;
      old_save  <= 1'b0;
      old_ack   <= 1'b0;
      timer     <= '0;
      sd.sd_lba <= '0;
      sd.sd_rd  <= 1'b0;
      sd.sd_wr  <= 1'b0;
      bk_ena    <= 1'b0;
      loading   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
`ifdef BK_DIRTY_TRACK_EN
      dirty     <= 1'b0;
`endif
    end else begin
      old_dl   <= download;
      old_load <= load_req & bk_ena;
      old_save <= save_req & bk_ena;
      old_ack  <= sd.sd_ack;
      done     <= 1'b0;
      err      <= 1'b0;

      if (dl_rise) bk_ena <= 1'b0;
      if (download & img_mounted & img_size_nz & ~img_readonly) bk_ena <= 1'b1;

      // A new ROM download invalidates whatever is in flight, silently.
      if (dl_rise && state != IDLE) begin
        sd.sd_rd <= 1'b0;
        sd.sd_wr <= 1'b0;
        busy     <= 1'b0;
        loading  <= 1'b0;
        state    <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              sd.sd_lba <= '0;
              sd.sd_rd  <= is_load;
              sd.sd_wr  <= ~is_load;
              loading   <= is_load;
              busy      <= 1'b1;
              timer     <= '0;
              state     <= REQ;
            end else if (skip_save) begin
              done <= 1'b1;
            end
          end
          REQ: begin
            if (ack_rise) begin
              sd.sd_rd <= 1'b0;
              sd.sd_wr <= 1'b0;
              state    <= XFER;
            end else if (time_up) begin
              sd.sd_rd <= 1'b0;
              sd.sd_wr <= 1'b0;
              busy     <= 1'b0;
              loading  <= 1'b0;
              err      <= 1'b1;
              state    <= IDLE;
            end else begin
              timer <= timer + 32'd1;
            end
          end
          XFER: begin
            if (ack_fall) begin
              if (sd.sd_lba >= last) begin
                busy    <= 1'b0;
                loading <= 1'b0;
                done    <= 1'b1;
                state   <= IDLE;
`ifdef BK_DIRTY_TRACK_EN
                dirty   <= 1'b0;
`endif
              end else begin
                sd.sd_lba <= sd.sd_lba + 1'b1;
                sd.sd_rd  <= loading;
                sd.sd_wr  <= ~loading;
                timer     <= '0;
                state     <= REQ;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
`ifdef BK_DIRTY_TRACK_EN
      // A write landing with a save's completion must survive for the next save.
      if (bsram_wr && !loading) dirty <= 1'b1;
`endif
    end
  end
endmodule

// File: tb/tb_bk_sd_sequencer.sv
// tb/tb_bk_sd_sequencer.sv - scoreboard bench for bk_sd_sequencer with an HPS sector-ack model
module tb_bk_sd_sequencer;
  localparam int LBA_W  = 32;
  localparam int MASK_W = 24;
  localparam int TO     = 16;

  logic              clk_sys = 1'b0;
  logic              reset = 1'b0;
  logic              download = 1'b0;
  logic              img_mounted = 1'b0;
  logic              img_size_nz = 1'b0;
  logic              img_readonly = 1'b0;
  logic              load_req = 1'b0;
  logic              save_req = 1'b0;
  logic              bsram_wr = 1'b0;
  logic [MASK_W-1:0] ram_mask = '0;
  logic              bk_ena, loading, busy, done, err;

  bk_sd_sequencer_if #(.LBA_W(LBA_W)) sd ();

  bk_sd_sequencer #(.LBA_W(LBA_W), .MASK_W(MASK_W), .BLK_BITS(9), .TIMEOUT(TO)) dut (
    .clk_sys(clk_sys), .reset(reset), .download(download), .img_mounted(img_mounted),
    .img_size_nz(img_size_nz), .img_readonly(img_readonly), .load_req(load_req),
    .save_req(save_req), .ram_mask(ram_mask), .bsram_wr(bsram_wr), .sd(sd),
    .bk_ena(bk_ena), .loading(loading), .busy(busy), .done(done), .err(err)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic             wr;
    logic [LBA_W-1:0] lba;
  } req_t;

  req_t exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int rd_cyc = 0;
  int wr_cyc = 0;

  always @(negedge clk_sys) begin
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (sd.sd_rd) rd_cyc++;
    if (sd.sd_wr) wr_cyc++;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic push_xfer(input logic wr, input int n);
    req_t r;
    for (int i = 0; i < n; i++) begin
      r.wr  = wr;
      r.lba = LBA_W'(i);
      exp_q.push_back(r);
    end
  endtask

  // Wait for the next sector request and score it against the queue head.
  task automatic expect_req(input logic exp_loading, output logic ok);
    int   w;
    req_t e;
    w  = 0;
    ok = 1'b0;
    while (!(sd.sd_rd || sd.sd_wr) && w < 40) begin
      tick();
      w++;
    end
    n_checks++;
    if (!(sd.sd_rd || sd.sd_wr) || exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL req_wait: request=%b queued=%0d, required request with queued entry",
               sd.sd_rd | sd.sd_wr, exp_q.size());
      exp_q.delete();
      return;
    end
    e = exp_q.pop_front();
    n_checks++;
    if (sd.sd_wr !== e.wr || sd.sd_rd !== ~e.wr || sd.sd_lba !== e.lba) begin
      n_errors++;
      $display("FAIL req_match: rd=%b wr=%b lba=%0d, required rd=%b wr=%b lba=%0d",
               sd.sd_rd, sd.sd_wr, sd.sd_lba, ~e.wr, e.wr, e.lba);
    end
    n_checks++;
    if (loading !== exp_loading || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL req_flags: loading=%b busy=%b, required loading=%b busy=1",
               loading, busy, exp_loading);
    end
    ok = 1'b1;
  endtask

  task automatic serve(input int n, input logic exp_loading);
    logic ok;
    for (int s = 0; s < n; s++) begin
      expect_req(exp_loading, ok);
      if (!ok) return;
      sd.sd_ack = 1'b1;
      tick(2);
      n_checks++;
      if (sd.sd_rd !== 1'b0 || sd.sd_wr !== 1'b0) begin
        n_errors++;
        $display("FAIL req_drop: rd=%b wr=%b after ack rise, required 0 0", sd.sd_rd, sd.sd_wr);
      end
      sd.sd_ack = 1'b0;
      tick();
    end
  endtask

  task automatic check_idle(input string name, input int d_done, input int d_err);
    tick(2);
    n_checks++;
    if (busy !== 1'b0 || loading !== 1'b0 || d_done != 0 && done_cnt == 0 ||
        sd.sd_rd !== 1'b0 || sd.sd_wr !== 1'b0) begin
      n_errors++;
      $display("FAIL %s_idle: busy=%b loading=%b rd=%b wr=%b, required all 0",
               name, busy, loading, sd.sd_rd, sd.sd_wr);
    end
    n_checks++;
    if (done_cnt !== d_done || err_cnt !== d_err) begin
      n_errors++;
      $display("FAIL %s_pulses: done=%0d err=%0d, required done=%0d err=%0d",
               name, done_cnt, err_cnt, d_done, d_err);
    end
  endtask

  task automatic remount();
    download = 1'b1;
    tick(2);
    img_mounted = 1'b1;
    img_size_nz = 1'b1;
    img_readonly = 1'b0;
    tick();
    img_mounted = 1'b0;
    ram_mask = '0;
    push_xfer(1'b0, 1);
    download = 1'b0;
    serve(1, 1'b1);
    tick(2);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(3);
    n_checks++;
    if (sd.sd_rd !== 1'b0 || sd.sd_wr !== 1'b0 || sd.sd_lba !== '0) begin
      n_errors++;
      $display("FAIL reset_sd: rd=%b wr=%b lba=%0d, required 0 0 0", sd.sd_rd, sd.sd_wr, sd.sd_lba);
    end
    n_checks++;
    if ({bk_ena, loading, busy, done, err} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_flags: %b, required 00000", {bk_ena, loading, busy, done, err});
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_mount_autoload();
    int d0;
    int w0;
    download = 1'b1;
    tick(2);
    img_mounted = 1'b1;
    img_size_nz = 1'b1;
    img_readonly = 1'b1;
    tick();
    img_mounted = 1'b0;
    n_checks++;
    if (bk_ena !== 1'b0) begin
      n_errors++;
      $display("FAIL mount_readonly: bk_ena=%b, required 0", bk_ena);
    end
    img_mounted = 1'b1;
    img_readonly = 1'b0;
    tick();
    img_mounted = 1'b0;
    n_checks++;
    if (bk_ena !== 1'b1) begin
      n_errors++;
      $display("FAIL mount_enable: bk_ena=%b, required 1", bk_ena);
    end
    ram_mask = 24'h1FFF;
    d0 = done_cnt;
    w0 = wr_cyc;
    push_xfer(1'b0, 16);
    download = 1'b0;
    tick();
    n_checks++;
    if (sd.sd_rd !== 1'b1 || loading !== 1'b1) begin
      n_errors++;
      $display("FAIL autoload_latency: rd=%b loading=%b, required 1 1", sd.sd_rd, loading);
    end
    serve(16, 1'b1);
    check_idle("autoload", d0 + 1, err_cnt);
    n_checks++;
    if (wr_cyc !== w0) begin
      n_errors++;
      $display("FAIL autoload_no_wr: wr cycles=%0d, required %0d", wr_cyc, w0);
    end
  endtask

  task automatic test_save();
    int d0;
    int r0;
    ram_mask = 24'h7FFF;
    d0 = done_cnt;
    r0 = rd_cyc;
    push_xfer(1'b1, 64);
    save_req = 1'b1;
    tick();
    n_checks++;
    if (sd.sd_wr !== 1'b1 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL save_latency: wr=%b busy=%b, required 1 1", sd.sd_wr, busy);
    end
    serve(64, 1'b0);
    save_req = 1'b0;
    check_idle("save", d0 + 1, err_cnt);
    n_checks++;
    if (rd_cyc !== r0 || sd.sd_lba !== 32'd63) begin
      n_errors++;
      $display("FAIL save_end: rd cycles=%0d lba=%0d, required %0d 63", rd_cyc, sd.sd_lba, r0);
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    int w0;
    int r0;
    ram_mask = 24'h01FF;
    d0 = done_cnt;
    w0 = wr_cyc;
    push_xfer(1'b0, 1);
    load_req = 1'b1;
    save_req = 1'b1;
    tick();
    serve(1, 1'b1);
    load_req = 1'b0;
    save_req = 1'b0;
    check_idle("simul", d0 + 1, err_cnt);
    n_checks++;
    if (wr_cyc !== w0) begin
      n_errors++;
      $display("FAIL simul_no_wr: wr cycles=%0d, required %0d", wr_cyc, w0);
    end
    ram_mask = 24'h03FF;
    d0 = done_cnt;
    r0 = rd_cyc;
    push_xfer(1'b1, 2);
    save_req = 1'b1;
    tick();
    serve(1, 1'b0);
    load_req = 1'b1;
    serve(1, 1'b0);
    check_idle("busy_ignore", d0 + 1, err_cnt);
    n_checks++;
    if (rd_cyc !== r0) begin
      n_errors++;
      $display("FAIL busy_ignore_no_rd: rd cycles=%0d, required %0d", rd_cyc, r0);
    end
    load_req = 1'b0;
    save_req = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int d0;
    int e0;
    int n;
    ram_mask = '0;
    d0 = done_cnt;
    e0 = err_cnt;
    save_req = 1'b1;
    tick();
    n = 0;
    while (sd.sd_wr === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    n_checks++;
    if (n !== TO) begin
      n_errors++;
      $display("FAIL timeout_len: wr high %0d cycles, required %0d", n, TO);
    end
    save_req = 1'b0;
    check_idle("timeout", d0, e0 + 1);
    n_checks++;
    if (sd.sd_lba !== '0) begin
      n_errors++;
      $display("FAIL timeout_lba: lba=%0d, required 0", sd.sd_lba);
    end
  endtask

  task automatic test_abort();
    int   d0;
    int   e0;
    logic ok;
    ram_mask = 24'h7FFF;
    push_xfer(1'b1, 4);
    save_req = 1'b1;
    tick();
    serve(3, 1'b0);
    expect_req(1'b0, ok);
    d0 = done_cnt;
    e0 = err_cnt;
    save_req = 1'b0;
    download = 1'b1;
    tick();
    n_checks++;
    if (sd.sd_wr !== 1'b0 || busy !== 1'b0 || bk_ena !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_clear: wr=%b busy=%b bk_ena=%b, required 0 0 0", sd.sd_wr, busy, bk_ena);
    end
    tick(2);
    download = 1'b0;
    tick(2);
    save_req = 1'b1;
    tick(4);
    save_req = 1'b0;
    check_idle("abort", d0, e0);
  endtask

  task automatic test_save_policy();
    int d0;
    int w0;
    remount();
`ifdef BK_DIRTY_TRACK_EN
    d0 = done_cnt;
    w0 = wr_cyc;
    save_req = 1'b1;
    tick(3);
    save_req = 1'b0;
    check_idle("clean_skip", d0 + 1, err_cnt);
    n_checks++;
    if (wr_cyc !== w0) begin
      n_errors++;
      $display("FAIL clean_skip_no_wr: wr cycles=%0d, required %0d", wr_cyc, w0);
    end
    bsram_wr = 1'b1;
    tick();
    bsram_wr = 1'b0;
    ram_mask = 24'h03FF;
    push_xfer(1'b1, 2);
    save_req = 1'b1;
    tick();
    serve(2, 1'b0);
    save_req = 1'b0;
    check_idle("dirty_save", d0 + 2, err_cnt);
    w0 = wr_cyc;
    save_req = 1'b1;
    tick(3);
    save_req = 1'b0;
    check_idle("resave_skip", d0 + 3, err_cnt);
    n_checks++;
    if (wr_cyc !== w0) begin
      n_errors++;
      $display("FAIL resave_no_wr: wr cycles=%0d, required %0d", wr_cyc, w0);
    end
`else
    d0 = done_cnt;
    w0 = wr_cyc;
    ram_mask = 24'h03FF;
    for (int k = 0; k < 2; k++) begin
      push_xfer(1'b1, 2);
      save_req = 1'b1;
      tick();
      serve(2, 1'b0);
      save_req = 1'b0;
      bsram_wr = 1'b1;
      tick();
      bsram_wr = 1'b0;
      check_idle("plain_save", d0 + k + 1, err_cnt);
    end
    n_checks++;
    if (wr_cyc - w0 !== 4) begin
      n_errors++;
      $display("FAIL plain_save_wr: wr cycles=%0d, required 4", wr_cyc - w0);
    end
`endif
  endtask

  initial begin
    sd.sd_ack = 1'b0;
    test_reset();
    test_mount_autoload();
    test_save();
    test_back_to_back();
    test_timeout();
    test_abort();
    test_save_policy();
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/bk_sd_sequencer.md
Name: bk_sd_sequencer

Overview:
Parametrised backup-RAM (BSRAM) transfer sequencer between on-chip BSRAM and the HPS SD image, sector by sector. Handles save-file enable on mount, auto-load after ROM download, and user load/save requests. Adds an ack timeout with error reporting and abort on new download. Sits beside hps_io in the emu top level. Drives sd_lba/sd_rd/sd_wr, and a loading flag that feeds system reset.

Parameters:
LBA_W, 32, width of sd_lba output
MASK_W, 24, width of ram_mask input (byte-address mask)
BLK_BITS, 9, log2 of sector size in bytes (512)
TIMEOUT, 2**24, clk_sys cycles allowed from request to sd_ack rise; 0 disables the timeout

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous, active-low
download  in  1  ROM download in progress (ioctl_download)
img_mounted  in  1  save image mount strobe
img_size_nz  in  1  mounted image size is non-zero
img_readonly  in  1  mounted image is read-only
load_req  in  1  user load request (level; rising edge acts)
save_req  in  1  user save request (level; rising edge acts)
ram_mask  in  MASK_W  BSRAM byte mask (size-1)
bsram_wr  in  1  core BSRAM write strobe (used only with the optional feature)
sd_ack  in  1  HPS sector acknowledge
sd_lba  out  LBA_W  current sector
sd_rd  out  1  sector read request
sd_wr  out  1  sector write request
bk_ena  out  1  valid writable save image present
loading  out  1  load transfer active
busy  out  1  any transfer active
done  out  1  one-cycle pulse on successful completion
err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (reset==0 at clk edge): all outputs 0, state IDLE, edge registers and timer cleared. Dirty flag is also cleared when the optional feature is compiled in.
- bk_ena: cleared on the rising edge of download. Set on any cycle with download & img_mounted & img_size_nz & ~img_readonly.
- Edge detection: old_load <= load_req & bk_ena; old_save <= save_req & bk_ena; old_ack <= sd_ack, all registered.
- last = ram_mask >> BLK_BITS (zero-extended to LBA_W). Sector count = last+1. ram_mask < 2**BLK_BITS gives exactly 1 sector.
- States: IDLE, REQ, XFER.
- IDLE start conditions, in priority order:
  - Falling edge of download with bk_ena set: auto-load.
  - Rising edge of load_req.
  - Rising edge of save_req.
  - Simultaneous load and save edges: load wins; the save edge is dropped.
- On start: sd_lba<=0; sd_rd<=is_load; sd_wr<=~is_load; loading<=is_load; busy<=1; timer<=0; go to REQ.
- REQ:
  - sd_ack rising (~old_ack & sd_ack): sd_rd<=0 and sd_wr<=0; go to XFER.
  - Otherwise the timer increments. When timer reaches TIMEOUT-1: clear sd_rd, sd_wr, busy and loading; pulse err; go to IDLE. sd_lba holds its value.
- XFER: on sd_ack falling (old_ack & ~sd_ack):
  - If sd_lba >= last: clear busy and loading; pulse done; go to IDLE.
  - Otherwise: sd_lba<=sd_lba+1; reassert the same request; timer<=0; go to REQ.
- Latency: request asserted 1 cycle after the triggering edge is registered. Each next sector is requested 1 cycle after the ack fall.
- Request edges arriving while busy are ignored and not queued.
- Rising edge of download mid-transfer: abort to IDLE, clearing sd_rd, sd_wr, busy and loading. No done or err pulse.
- sd_lba does not wrap: it stops at last.
- Reset mid-transfer behaves as reset: everything cleared, no pulse.

Optional Feature:
Macro: BK_DIRTY_TRACK_EN.
- Defined:
  - An internal dirty flag is set by bsram_wr while not loading.
  - dirty is cleared on done of either a load or a save.
  - A save edge with dirty==0 starts nothing and pulses done for 1 cycle.
  - bsram_wr in the same cycle as a save's done leaves dirty set.
- Undefined: bsram_wr is ignored, and every save request performs the full transfer.

Test Plan:
- Mount strobe during download with size_nz, writable -> bk_ena=1. Release download, ram_mask=0x1FFF -> auto-load: sd_rd for lba 0..15, loading=1 throughout, single done pulse after lba 15 ack falls.
- bk_ena=1, idle, save_req rise, ram_mask=0x7FFF -> sd_wr per sector lba 0..63, sd_rd never asserted, done once, busy=0 after.
- load_req and save_req rise on the same cycle -> load transfer only; sd_wr stays 0.
- TIMEOUT=16, save_req, sd_ack held low -> sd_wr drops at cycle 16 after the request, err pulse 1 cycle, busy=0, no done.
- Mid-save at lba 3, download rises -> sd_wr=0, busy=0, bk_ena=0, no done/err. Later save_req -> ignored while bk_ena=0.
- With BK_DIRTY_TRACK_EN: save with no bsram_wr -> done pulse, no sd_wr. After one bsram_wr, save -> full transfer, and the next save is skipped again.
